// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction prefetcher between the core
// fetch port and a req/gnt/rvalid memory of arbitrary latency. Prefetched
// words queue in a DEPTH-entry FIFO; any non-sequential fetch flushes the
// FIFO and marks all outstanding responses for discard.
module inst_prefetch_buffer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 2;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [INST_W-1:0] fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] deliver_addr_q, deliver_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              stale_q, stale_d;

    logic              redirect;
    logic              hit;
    logic              fifo_we;
    logic              gnt_keep;
    logic              rsp_any;
    logic [SW-1:0]     credit_used;

    // Next-state: redirect/hit/wait decode, counter bookkeeping and request issue.
    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        cnt_d          = cnt_q;
        inflight_d     = inflight_q;
        discard_d      = discard_q;
        fetch_addr_d   = fetch_addr_q;
        deliver_addr_d = deliver_addr_q;
        stale_d        = stale_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        hit            = 1'b0;
        fifo_we        = 1'b0;
        gnt_keep       = 1'b0;
        credit_used    = '0;

        redirect = if_req_i && (state_q == IDLE || if_addr_i != deliver_addr_q);
        rsp_any  = mem_rvalid_i && (inflight_q != '0 || discard_q != '0);

        if (redirect) begin
            // Everything outstanding becomes discard. A still-pending request is
            // counted here once and flagged stale so its later grant adds nothing.
            state_d        = RUN;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            cnt_d          = '0;
            inflight_d     = '0;
            discard_d      = discard_q + inflight_q + CW'(mem_req_q && !stale_q) - CW'(rsp_any);
            stale_d        = mem_req_q && !mem_gnt_i;
            fetch_addr_d   = if_addr_i;
            deliver_addr_d = if_addr_i;
        end else begin
            hit = if_req_i && state_q == RUN && cnt_q != '0;
            if (hit) begin
                rd_ptr_d       = rd_ptr_q + PW'(1);
                deliver_addr_d = deliver_addr_q + ADDR_W'(INST_BYTES);
            end
            if (mem_req_q && mem_gnt_i) begin
                if (stale_q) begin
                    stale_d = 1'b0;
                end else begin
                    gnt_keep     = 1'b1;
                    fetch_addr_d = fetch_addr_q + ADDR_W'(INST_BYTES);
                end
            end
            if (rsp_any) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    fifo_we = 1'b1;
                end
            end
            if (fifo_we) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(gnt_keep) - CW'(fifo_we);
            cnt_d      = cnt_q + CW'(fifo_we) - CW'(hit);
        end

        if (mem_req_q && !mem_gnt_i) begin
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
        end else begin
            credit_used = SW'(cnt_d) + SW'(inflight_d) + SW'(discard_d);
            mem_req_d   = (state_d == RUN) && (credit_used < SW'(DEPTH));
            mem_addr_d  = fetch_addr_d;
        end
    end

    // Control and address state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
            inflight_q     <= '0;
            discard_q      <= '0;
            fetch_addr_q   <= '0;
            deliver_addr_q <= '0;
            mem_addr_q     <= '0;
            mem_req_q      <= 1'b0;
            stale_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
            inflight_q     <= inflight_d;
            discard_q      <= discard_d;
            fetch_addr_q   <= fetch_addr_d;
            deliver_addr_q <= deliver_addr_d;
            mem_addr_q     <= mem_addr_d;
            mem_req_q      <= mem_req_d;
            stale_q        <= stale_d;
        end
    end

    // FIFO storage; contents are only read for occupied entries.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    assign if_valid_o = hit;
    assign if_inst_o  = hit ? fifo_q[rd_ptr_q] : '0;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // A response with nothing outstanding breaks the memory protocol; it is ignored above.
    rvalid_expected_a: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid_i |-> (inflight_q != '0 || discard_q != '0));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Testbench for inst_prefetch_buffer: directed latency/flush/wrap scenarios
// plus a randomized run, all checked by a word-per-address scoreboard.
module tb_inst_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    inst_prefetch_buffer #(
        .ADDR_W     (32),
        .INST_W     (32),
        .DEPTH      (4),
        .INST_BYTES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_inst_o    (if_inst_o),
        .if_valid_o   (if_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Memory model configuration and state.
    int unsigned mem_lat   = 1;
    int unsigned gnt_pct   = 100;
    bit          gnt_block = 1'b0;
    int unsigned mcyc      = 0;
    int unsigned grants    = 0;
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } rsp_t;
    rsp_t rsp_q[$];

    // Scoreboard: expected instruction words in delivery order.
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr = '0;
    bit          have_pend = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One core cycle: drive the fetch port at the falling edge, report delivery.
    task automatic step(input bit req, input logic [31:0] addr, output bit got);
        @(negedge clk);
        if_req_i  = req;
        if_addr_i = addr;
        if (req && (!have_pend || pend_addr != addr)) begin
            if (have_pend && exp_q.size() > 0) void'(exp_q.pop_back());
            exp_q.push_back(word_at(addr));
            have_pend = 1'b1;
            pend_addr = addr;
        end
        #1;
        got = if_valid_o;
        if (got) have_pend = 1'b0;
    endtask

    task automatic hold_reset();
        if_req_i  = 1'b0;
        if_addr_i = '0;
        exp_q.delete();
        have_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hold_reset();
    endtask

    // Memory: grants at random, answers in order mem_lat cycles after grant.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                mem_gnt_i    = 1'b0;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end else begin
                mcyc++;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
                if (rsp_q.size() > 0 && rsp_q[0].due <= mcyc) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = word_at(rsp_q[0].addr);
                    void'(rsp_q.pop_front());
                end
                mem_gnt_i = mem_req_o && !gnt_block && ($urandom_range(99) < gnt_pct);
                if (mem_gnt_i) begin
                    rsp_q.push_back('{addr: mem_addr_o, due: mcyc + mem_lat});
                    grants++;
                end
            end
        end
    end

    // Monitor: every delivered instruction must match the scoreboard head.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (if_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", {32'h0, if_inst_o}, 64'hDEAD_0000_0000_0000);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_data", {32'h0, if_inst_o}, {32'h0, exp});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [31:0] cur;
        int unsigned g0;
        int unsigned waits;
        int unsigned max_wait;
        int unsigned served;
        int unsigned r;

        if_req_i  = 1'b0;
        if_addr_i = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_if_valid", if_valid_o, 0);
        check("rst_if_inst", if_inst_o, 0);
        hold_reset();

        // 1: zero-wait memory, first word three cycles after the first request.
        cur = 32'h0;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, cur, got);
            check("t1_valid", got, (c >= 3) ? 1 : 0);
            if (got) cur += 4;
        end

        // 2: core stall fills the FIFO and stops requests; resume drains 4 in 4.
        for (int c = 0; c < 8; c++) begin
            step(1'b0, cur, got);
            if (c == 3) g0 = grants;
        end
        check("t2_req_dropped", mem_req_o, 0);
        check("t2_no_grants", grants, g0);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, cur, got);
            check("t2_drain", got, 1);
            if (got) cur += 4;
            if (c == 1) check("t2_refill", mem_req_o, 1);
        end

        // 3: latency 3, jump to 0x100 with two requests outstanding.
        do_reset();
        mem_lat = 3;
        step(1'b1, 32'h0, got);
        step(1'b1, 32'h0, got);
        check("t3_no_early", got, 0);
        for (int c = 2; c <= 7; c++) begin
            step(1'b1, 32'h100, got);
            check("t3_first", got, (c == 7) ? 1 : 0);
        end
        step(1'b1, 32'h104, got);
        check("t3_second", got, 1);

        // 4: grant withheld, redirect while the request is stuck.
        do_reset();
        mem_lat   = 1;
        gnt_block = 1'b1;
        step(1'b1, 32'h0, got);
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, (c >= 3) ? 32'h200 : 32'h0, got);
            check("t4_req_hold", mem_req_o, 1);
            check("t4_addr_hold", mem_addr_o, 0);
        end
        gnt_block = 1'b0;
        step(1'b1, 32'h200, got);
        check("t4_addr_at_gnt", mem_addr_o, 0);
        step(1'b1, 32'h200, got);
        check("t4_new_addr", mem_addr_o, 32'h200);
        check("t4_new_req", mem_req_o, 1);
        step(1'b1, 32'h200, got);
        check("t4_wait", got, 0);
        step(1'b1, 32'h200, got);
        check("t4_first", got, 1);

        // 5: reset mid-burst clears outputs without a clock edge; restart at 0x40.
        do_reset();
        cur = 32'h0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, cur, got);
            if (got) cur += 4;
        end
        #2 rst = 1'b1;
        #1;
        check("t5_mem_req", mem_req_o, 0);
        check("t5_mem_addr", mem_addr_o, 0);
        check("t5_if_valid", if_valid_o, 0);
        check("t5_if_inst", if_inst_o, 0);
        hold_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 32'h40, got);
            check("t5_restart", got, (c == 3) ? 1 : 0);
        end

        // 6: sequential fetch across the top of the address space.
        do_reset();
        cur = 32'hFFFF_FFF8;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, cur, got);
            check("t6_wrap", got, (c >= 3) ? 1 : 0);
            if (got) cur += 4;
        end

        // Randomized: stalls, jumps, variable latency and grant rate.
        do_reset();
        cur      = 32'h1000;
        waits    = 0;
        max_wait = 0;
        served   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                mem_lat = $urandom_range(1, 4);
                gnt_pct = $urandom_range(30, 100);
            end
            r = $urandom_range(99);
            if (r < 12) begin
                step(1'b0, cur, got);
            end else begin
                if (r < 17) begin
                    cur = (($urandom_range(1) == 0) ? 32'hFFFF_FF00 : 32'h0000_1000)
                          + 32'($urandom_range(0, 63)) * 4;
                end
                step(1'b1, cur, got);
                if (got) begin
                    cur += 4;
                    served++;
                    waits = 0;
                end else begin
                    waits++;
                    if (waits > max_wait) max_wait = waits;
                end
            end
            if (waits > 100) break;
        end
        check("rnd_progress", (max_wait <= 100) ? 1 : 0, 1);
        check("rnd_served", (served > 300) ? 1 : 0, 1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
